// File: rtl/eth_tx_frame_sequencer.sv
// Transmit frame sequencer: pops a length word, streams that many bytes from the data FIFO to the MAC,
// zero-pads short frames, drains zero/oversize requests, and enforces an inter-frame gap.
module eth_tx_frame_sequencer #(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1518,
  parameter int IFG_CYC = 12
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        clk_en,
  input  logic [15:0] tx_len_fifo_data,
  input  logic        tx_len_fifo_empty,
  output logic        tx_len_fifo_read,
  input  logic [7:0]  tx_data_fifo_data,
  input  logic        tx_data_fifo_empty,
  output logic        tx_data_fifo_read,
  output logic [7:0]  tx_fifodata,
  output logic        tx_fifoavail,
  output logic        tx_fifoeof,
  input  logic        tx_macread,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_drop,
  output logic [15:0] tx_frame_cnt
);

  localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [15:0] IFG_LAST  = (IFG_CYC > 0) ? 16'(IFG_CYC - 1) : 16'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_IFG
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] len_reg, len_next;
  logic [15:0] pad_reg, pad_next;
  logic [15:0] sent_reg, sent_next;
  logic [15:0] ifg_reg, ifg_next;
  logic [15:0] frame_cnt_reg, frame_cnt_next;
  logic [7:0]  data_reg, data_next;
  logic        avail_reg, avail_next;
  logic        eof_reg, eof_next;
  logic        done_reg, done_next;
  logic        drop_reg, drop_next;
  logic        len_pop, data_pop;
  logic        load, accept, load_ok;

  assign accept  = avail_reg && tx_macread;
  assign load_ok = !avail_reg || tx_macread;

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      len_reg       <= '0;
      pad_reg       <= '0;
      sent_reg      <= '0;
      ifg_reg       <= '0;
      frame_cnt_reg <= '0;
      data_reg      <= '0;
      avail_reg     <= 1'b0;
      eof_reg       <= 1'b0;
      done_reg      <= 1'b0;
      drop_reg      <= 1'b0;
    end else if (clk_en) begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      pad_reg       <= pad_next;
      sent_reg      <= sent_next;
      ifg_reg       <= ifg_next;
      frame_cnt_reg <= frame_cnt_next;
      data_reg      <= data_next;
      avail_reg     <= avail_next;
      eof_reg       <= eof_next;
      done_reg      <= done_next;
      drop_reg      <= drop_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    pad_next       = pad_reg;
    sent_next      = sent_reg;
    ifg_next       = ifg_reg;
    frame_cnt_next = frame_cnt_reg;
    data_next      = data_reg;
    avail_next     = avail_reg;
    eof_next       = eof_reg;
    done_next      = 1'b0;
    drop_next      = 1'b0;
    len_pop        = 1'b0;
    data_pop       = 1'b0;
    load           = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (!tx_len_fifo_empty) begin
          len_pop   = 1'b1;
          len_next  = tx_len_fifo_data;
          sent_next = '0;
          pad_next  = (tx_len_fifo_data < MIN_LEN_W) ? MIN_LEN_W : tx_len_fifo_data;
          if (tx_len_fifo_data == 16'd0)
            drop_next = 1'b1;
          else if (tx_len_fifo_data > MAX_LEN_W)
            state_next = S_DRAIN;
          else
            state_next = S_STREAM;
        end
      end

      S_STREAM: begin
        if (accept && eof_reg) begin
          avail_next     = 1'b0;
          eof_next       = 1'b0;
          done_next      = 1'b1;
          frame_cnt_next = frame_cnt_reg + 16'd1;
          ifg_next       = '0;
          state_next     = S_IFG;
        end else begin
          if (accept)
            avail_next = 1'b0;
          if (load_ok && (sent_reg < pad_reg)) begin
            // Below L the byte comes from the FIFO; between L and P it is zero padding.
            if (sent_reg < len_reg) begin
              if (!tx_data_fifo_empty) begin
                data_pop  = 1'b1;
                data_next = tx_data_fifo_data;
                load      = 1'b1;
              end
            end else begin
              data_next = 8'h00;
              load      = 1'b1;
            end
            if (load) begin
              avail_next = 1'b1;
              eof_next   = (sent_reg == (pad_reg - 16'd1));
              sent_next  = sent_reg + 16'd1;
            end
          end
        end
      end

      S_DRAIN: begin
        // len_reg counts down the bytes still to discard.
        if (!tx_data_fifo_empty) begin
          data_pop = 1'b1;
          len_next = len_reg - 16'd1;
          if (len_reg == 16'd1) begin
            drop_next  = 1'b1;
            ifg_next   = '0;
            state_next = S_IFG;
          end
        end
      end

      S_IFG: begin
        if (ifg_reg == IFG_LAST)
          state_next = S_IDLE;
        else
          ifg_next = ifg_reg + 16'd1;
      end

      default: state_next = S_IDLE;
    endcase
  end

  // Pops fire once per enabled cycle, in the same cycle the popped word is captured.
  assign tx_len_fifo_read  = clk_en && !reset && len_pop;
  assign tx_data_fifo_read = clk_en && !reset && data_pop;

  assign tx_fifodata  = data_reg;
  assign tx_fifoavail = avail_reg;
  assign tx_fifoeof   = eof_reg;
  assign tx_busy      = (state_reg != S_IDLE);
  assign tx_done      = done_reg;
  assign tx_drop      = drop_reg;
  assign tx_frame_cnt = frame_cnt_reg;

endmodule
